// File: rtl/bs_step_unit.sv
// One FM-index backward-search step: reads C(sym), then Occ(sym,k-1) and Occ(sym,l),
// and returns the new SA interval (C+Occ(k-1)+1, C+Occ(l)), with a per-read timeout.
module bs_step_unit #(
   parameter int POS_W   = 8,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_sym,
   input  logic [POS_W-1:0]   req_k,
   input  logic [POS_W-1:0]   req_l,
   output logic               ce_rom_C_o,
   output logic [1:0]         addr_rom_C_o,
   input  logic [CNT_W-1:0]   data_C_i,
   output logic               ce_rom_Occ_o,
   output logic [POS_W-1:0]   addr_rom_Occ_o,
   input  logic [4*CNT_W-1:0] data_Occ_i,
   input  logic               data_valid_i,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [POS_W:0]     rsp_k,
   output logic [POS_W:0]     rsp_l,
   output logic               rsp_empty,
   output logic               rsp_err
);

   localparam int RW = POS_W + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, RD_C, RD_K, RD_L, RESP} state_t;

   state_t           state, state_nxt;
   logic             alive;
   logic [1:0]       sym;
   logic [POS_W-1:0] k, l;
   logic [CNT_W-1:0] c_val, occ_k, occ_sel;
   logic [TW-1:0]    wait_cnt;
   logic             timed_out;
   logic [RW-1:0]    new_k, new_l;

   assign occ_sel   = data_Occ_i[sym*CNT_W +: CNT_W];
   assign timed_out = !data_valid_i && (wait_cnt == TW'(TIMEOUT - 1));
   assign new_k     = RW'(c_val) + RW'(occ_k) + RW'(1);
   assign new_l     = RW'(c_val) + RW'(occ_sel);

   // alive keeps req_ready low while reset is held and for no longer
   assign req_ready = (state == IDLE) && alive;
   assign rsp_valid = (state == RESP);

   always_comb begin
      state_nxt      = state;
      ce_rom_C_o     = 1'b0;
      addr_rom_C_o   = 2'b00;
      ce_rom_Occ_o   = 1'b0;
      addr_rom_Occ_o = '0;
      case (state)
         IDLE: if (req_valid && alive) state_nxt = RD_C;
         RD_C: begin
            ce_rom_C_o   = 1'b1;
            addr_rom_C_o = sym;
            state_nxt    = (k != '0) ? RD_K : RD_L;
         end
         RD_K: begin
            ce_rom_Occ_o   = 1'b1;
            addr_rom_Occ_o = k - POS_W'(1);
            if (data_valid_i)   state_nxt = RD_L;
            else if (timed_out) state_nxt = RESP;
         end
         RD_L: begin
            ce_rom_Occ_o   = 1'b1;
            addr_rom_Occ_o = l;
            if (data_valid_i || timed_out) state_nxt = RESP;
         end
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         alive     <= 1'b0;
         sym       <= '0;
         k         <= '0;
         l         <= '0;
         c_val     <= '0;
         occ_k     <= '0;
         wait_cnt  <= '0;
         rsp_k     <= '0;
         rsp_l     <= '0;
         rsp_empty <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         alive <= 1'b1;
         case (state)
            IDLE: if (req_valid && alive) begin
               sym <= req_sym;
               k   <= req_k;
               l   <= req_l;
            end
            RD_C: begin
               c_val    <= data_C_i;
               occ_k    <= '0;
               wait_cnt <= '0;
            end
            RD_K: begin
               if (data_valid_i) begin
                  occ_k    <= occ_sel;
                  wait_cnt <= '0;
               end else if (timed_out) begin
                  rsp_k     <= '0;
                  rsp_l     <= '0;
                  rsp_empty <= 1'b1;
                  rsp_err   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            RD_L: begin
               if (data_valid_i) begin
                  rsp_k     <= new_k;
                  rsp_l     <= new_l;
                  rsp_empty <= (new_k > new_l);
                  rsp_err   <= 1'b0;
               end else if (timed_out) begin
                  rsp_k     <= '0;
                  rsp_l     <= '0;
                  rsp_empty <= 1'b1;
                  rsp_err   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bs_step_unit.sv
// Bench for bs_step_unit: directed FM-index steps plus randomized steps with wait states and
// backpressure, checked against plain-arithmetic C/Occ lookups over bench-owned ROM arrays.
module tb_bs_step_unit;

   localparam int POS_W   = 8;
   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 16;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic [1:0]         req_sym = '0;
   logic [POS_W-1:0]   req_k = '0;
   logic [POS_W-1:0]   req_l = '0;
   logic               ce_rom_C_o;
   logic [1:0]         addr_rom_C_o;
   logic [CNT_W-1:0]   data_C_i;
   logic               ce_rom_Occ_o;
   logic [POS_W-1:0]   addr_rom_Occ_o;
   logic [4*CNT_W-1:0] data_Occ_i;
   logic               data_valid_i;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic [POS_W:0]     rsp_k;
   logic [POS_W:0]     rsp_l;
   logic               rsp_empty;
   logic               rsp_err;

   int checks = 0;
   int errors = 0;
   int wait_cycles = 0;
   bit stuck = 1'b0;
   int wait_ctr = 0;
   logic [CNT_W-1:0]   c_rom [4];
   logic [4*CNT_W-1:0] occ_rom [256];
   int occ_seen [$];
   logic prev_wait = 1'b0;
   logic [POS_W-1:0] prev_addr = '0;

   bs_step_unit #(.POS_W(POS_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_sym(req_sym),
      .req_k(req_k), .req_l(req_l),
      .ce_rom_C_o(ce_rom_C_o), .addr_rom_C_o(addr_rom_C_o), .data_C_i(data_C_i),
      .ce_rom_Occ_o(ce_rom_Occ_o), .addr_rom_Occ_o(addr_rom_Occ_o),
      .data_Occ_i(data_Occ_i), .data_valid_i(data_valid_i),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_k(rsp_k), .rsp_l(rsp_l),
      .rsp_empty(rsp_empty), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   // Memory model: combinational ROMs, Occ valid after wait_cycles idle cycles per read
   assign data_C_i     = c_rom[addr_rom_C_o];
   assign data_Occ_i   = occ_rom[addr_rom_Occ_o];
   assign data_valid_i = ce_rom_Occ_o && !stuck && (wait_ctr >= wait_cycles);

   always @(posedge clk) begin
      if (!ce_rom_Occ_o || data_valid_i) wait_ctr <= 0;
      else                               wait_ctr <= wait_ctr + 1;
   end

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Records every Occ row actually delivered and checks the address holds during waits
   always @(negedge clk) begin
      if (rst_n && ce_rom_Occ_o) begin
         if (data_valid_i) occ_seen.push_back(int'(addr_rom_Occ_o));
         if (prev_wait) check_output("occ_addr_stable", 64'(addr_rom_Occ_o), 64'(prev_addr));
         prev_wait <= !data_valid_i;
         prev_addr <= addr_rom_Occ_o;
      end else begin
         prev_wait <= 1'b0;
      end
   end

   function automatic int occ_byte(input int row, input int s);
      logic [4*CNT_W-1:0] w;
      w = occ_rom[row];
      return int'(w[s*CNT_W +: CNT_W]);
   endfunction

   function automatic logic [63:0] all_outputs();
      return 64'({req_ready, ce_rom_C_o, addr_rom_C_o, ce_rom_Occ_o, addr_rom_Occ_o,
                  rsp_valid, rsp_k, rsp_l, rsp_empty, rsp_err});
   endfunction

   task automatic apply_stimulus(input logic [1:0] s, input logic [POS_W-1:0] k,
                                 input logic [POS_W-1:0] l, input int w, input int hold,
                                 input bit timeout_case);
      int cyc, reads, exp_lat, ek, el, ee, er;
      wait_cycles = w;
      stuck = timeout_case;
      occ_seen.delete();
      cyc = 0;
      while (!req_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check_output("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_sym = s;
      req_k = k;
      req_l = l;
      @(negedge clk);
      req_valid = 1'b0;
      req_sym = 2'($urandom);
      req_k = POS_W'($urandom);
      req_l = POS_W'($urandom);
      check_output("req_ready_busy", 64'(req_ready), 64'd0);
      cyc = 1;
      while (!rsp_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      reads = (k != 0) ? 2 : 1;
      if (timeout_case) begin
         exp_lat = 2 + TIMEOUT;
         ek = 0; el = 0; ee = 1; er = 1;
         reads = 0;
      end else begin
         exp_lat = 2 + reads * (w + 1);
         ek = int'(c_rom[s]) + ((k == 0) ? 0 : occ_byte(int'(k) - 1, int'(s))) + 1;
         el = int'(c_rom[s]) + occ_byte(int'(l), int'(s));
         ee = (ek > el) ? 1 : 0;
         er = 0;
      end
      check_output("latency", 64'(cyc), 64'(exp_lat));
      check_output("rsp_k", 64'(rsp_k), 64'(ek));
      check_output("rsp_l", 64'(rsp_l), 64'(el));
      check_output("rsp_empty", 64'(rsp_empty), 64'(ee));
      check_output("rsp_err", 64'(rsp_err), 64'(er));
      check_output("occ_read_count", 64'(occ_seen.size()), 64'(reads));
      if (occ_seen.size() == 2) check_output("occ_addr_k", 64'(occ_seen[0]), 64'(int'(k) - 1));
      if (occ_seen.size() == reads && reads > 0)
         check_output("occ_addr_l", 64'(occ_seen[reads-1]), 64'(l));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_output("rsp_held", 64'({rsp_valid, req_ready, rsp_empty, rsp_err, rsp_k, rsp_l}),
                      64'({1'b1, 1'b0, 1'(ee), 1'(er), 9'(ek), 9'(el)}));
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_output("after_handshake", 64'({rsp_valid, req_ready}), 64'(2'b01));
      stuck = 1'b0;
   endtask

   initial begin
      int cyc, seen;
      for (int i = 0; i < 4; i++) c_rom[i] = CNT_W'($urandom);
      for (int i = 0; i < 256; i++) occ_rom[i] = $urandom;
      c_rom[0] = 8'd0;
      c_rom[1] = 8'd4;
      c_rom[2] = 8'd10;
      c_rom[3] = 8'd255;
      occ_rom[4]   = 32'h03050702;
      occ_rom[9]   = 32'h04080702;
      occ_rom[2]   = 32'h00000300;
      occ_rom[6]   = 32'h11220344;
      occ_rom[254] = 32'hFF000000;
      occ_rom[255] = 32'hFF000000;

      repeat (3) @(negedge clk);
      check_output("reset_outputs", all_outputs(), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("ready_after_reset", 64'(req_ready), 64'd1);

      $display("[TB] directed steps");
      apply_stimulus(2'd2, 8'd5, 8'd9, 0, 0, 1'b0);
      apply_stimulus(2'd0, 8'd0, 8'd9, 0, 0, 1'b0);
      apply_stimulus(2'd1, 8'd3, 8'd6, 0, 1, 1'b0);
      apply_stimulus(2'd2, 8'd5, 8'd9, 3, 5, 1'b0);
      apply_stimulus(2'd3, 8'd255, 8'd255, 1, 0, 1'b0);

      $display("[TB] timeout then recovery");
      apply_stimulus(2'd2, 8'd5, 8'd9, 0, 2, 1'b1);
      apply_stimulus(2'd2, 8'd5, 8'd9, 0, 0, 1'b0);

      $display("[TB] reset during RD_L");
      wait_cycles = 0;
      req_valid = 1'b1;
      req_sym = 2'd2;
      req_k = 8'd5;
      req_l = 8'd9;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_output("in_rd_l", 64'({ce_rom_Occ_o, addr_rom_Occ_o}), 64'({1'b1, 8'd9}));
      rst_n = 1'b0;
      #1;
      check_output("reset_midop_outputs", all_outputs(), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      check_output("no_rsp_after_reset", 64'(seen), 64'd0);
      apply_stimulus(2'd2, 8'd5, 8'd9, 0, 0, 1'b0);

      $display("[TB] random steps");
      for (int i = 0; i < 24; i++)
         apply_stimulus(2'($urandom), POS_W'($urandom), POS_W'($urandom),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bs_step_unit.md
Name: bs_step_unit

Overview:
- Single backward-search step engine for the FM-index accelerator.
- Accepts an SA interval (k, l) and a symbol, then reads C(sym) from the C ROM.
- Reads Occ(sym, k-1) and Occ(sym, l) from the Occ ROM through its ce/addr/data/valid port, and returns the updated interval.
- Sits directly upstream of rom_C and rom_Occ, which it drives, and downstream of the search controller, which issues requests and consumes responses.

Parameters:
- POS_W, 8, width of SA positions and of the Occ ROM address.
- CNT_W, 8, width of one C entry and of one per-symbol Occ count; Occ word is 4*CNT_W.
- TIMEOUT, 16, maximum cycles to wait for data_valid_i per Occ read before aborting.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_sym  in  2  symbol (0=A,1=C,2=G,3=T)
- req_k  in  POS_W  interval lower bound
- req_l  in  POS_W  interval upper bound
- ce_rom_C_o  out  1  C ROM enable
- addr_rom_C_o  out  2  C ROM symbol address
- data_C_i  in  CNT_W  C(sym); combinational from addr
- ce_rom_Occ_o  out  1  Occ ROM enable
- addr_rom_Occ_o  out  POS_W  Occ ROM row address
- data_Occ_i  in  4*CNT_W  Occ row {T,G,C,A}; symbol s is bits [s*CNT_W +: CNT_W]
- data_valid_i  in  1  data_Occ_i valid this cycle
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_k  out  POS_W+1  new lower bound
- rsp_l  out  POS_W+1  new upper bound
- rsp_empty  out  1  rsp_k > rsp_l
- rsp_err  out  1  Occ read timed out

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset:
  - State goes to IDLE, all internal registers clear.
  - req_ready=0 during reset, then 1 from the first cycle after rst_n deasserts.
  - All other outputs are 0.
- Asserting rst_n low in any state aborts the step immediately; no response is produced.
- FSM states: IDLE, RD_C, RD_K, RD_L, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch sym/k/l and go to RD_C.
  - Only IDLE asserts req_ready.
- RD_C:
  - ce_rom_C_o=1, addr_rom_C_o=sym.
  - Capture data_C_i at end of cycle.
  - Go to RD_K if k!=0. If k==0, set occ_k=0 and go to RD_L.
- RD_K:
  - ce_rom_Occ_o=1, addr_rom_Occ_o=k-1, held stable.
  - On the first cycle with data_valid_i=1, capture the sym byte into occ_k and go to RD_L.
- RD_L:
  - ce_rom_Occ_o=1, addr_rom_Occ_o=l.
  - On data_valid_i=1, capture occ_l.
  - Register rsp_k = C + occ_k + 1 and rsp_l = C + occ_l, both zero-extended to POS_W+1 with no truncation.
  - Register rsp_empty = (rsp_k > rsp_l) and go to RESP.
- Timeout:
  - A wait counter resets on entry to RD_K and to RD_L.
  - If TIMEOUT consecutive cycles pass without data_valid_i, go to RESP with rsp_err=1, rsp_k=0, rsp_l=0, rsp_empty=1.
- Occ enable scope: ce_rom_Occ_o is 0 outside RD_K/RD_L, and addr_rom_Occ_o is 0 when ce is low. The same rule applies to ce_rom_C_o and addr_rom_C_o outside RD_C.
- data_valid_i is ignored outside RD_K/RD_L.
- RESP:
  - rsp_valid=1, and response fields are held stable until rsp_ready=1.
  - After the handshake, go to IDLE with rsp_valid=0 next cycle.
  - Only then can a new request be accepted; there is no same-cycle request/response overlap.
- Latency with zero-wait memory (data_valid_i tied 1):
  - Request accepted in cycle n.
  - RD_C in n+1, RD_K in n+2, RD_L in n+3, rsp_valid=1 in n+4.
  - With k==0 the response arrives in n+3.
  - Each memory wait cycle adds one cycle.
- req_sym, req_k and req_l may change after acceptance without effect.

Test Plan:
- Basic step (zero-wait model; C[2]=10; Occ[4]=0x03050702; Occ[9]=0x04080702):
  - Stimulus: sym=2, k=5, l=9.
  - Required: Occ addresses 4 then 9; rsp_k=16, rsp_l=18, rsp_empty=0, rsp_err=0; rsp_valid in cycle n+4.
- k==0:
  - Stimulus: sym=0, k=0, l=9; C[0]=0; Occ[9] A byte=2.
  - Required: single Occ access at address 9; rsp_k=1, rsp_l=2; rsp_valid in cycle n+3.
- Empty interval:
  - Setup: C[1]=4; Occ[2] and Occ[6] both have C byte=3.
  - Stimulus: sym=1, k=3, l=6.
  - Required: rsp_k=8, rsp_l=7, rsp_empty=1.
- Wait states and backpressure:
  - Stimulus: data_valid_i delayed 3 cycles per read; rsp_ready held 0 for 5 cycles.
  - Required: addr held stable throughout each wait; response fields stable until handshake; req_ready=0 until the cycle after the handshake.
- Timeout:
  - Stimulus: data_valid_i stuck at 0 in RD_K.
  - Required: after 16 cycles, rsp_valid=1, rsp_err=1, rsp_k=rsp_l=0, rsp_empty=1; next request after the handshake processes normally.
- Reset mid-operation:
  - Stimulus: rst_n pulled low while in RD_L.
  - Required: all outputs 0 immediately; no response after release; next request yields the correct result.
